// File: rtl/stb_dcache_drain_pkg.sv
// Shared widths and state type for the store-buffer drain engine.
package stb_dcache_drain_pkg;

    localparam int DCACHE_ADDR_WIDTH = 32;
    localparam int DCACHE_DATA_WIDTH = 32;
    // Byte lanes per data word; also the width of the byte mask.
    localparam int BLEN              = DCACHE_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stb_drain_state_t;

endpackage

// File: rtl/stb_dcache_drain_perf.sv
// Saturating performance counters for the drain engine.
// Instantiated by stb_dcache_drain only when STB_DRAIN_PERF_EN is defined.
module stb_dcache_drain_perf #(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_inc,
    input  logic                  stall_inc,
    input  logic                  ld_block_inc,
    output logic [PERF_CNT_W-1:0] drain_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] ld_block_cnt
);

    // Each counter advances on its event and sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt    <= '0;
            stall_cnt    <= '0;
            ld_block_cnt <= '0;
        end else begin
            if (drain_inc && (drain_cnt != '1))
                drain_cnt <= drain_cnt + 1'b1;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (ld_block_inc && (ld_block_cnt != '1))
                ld_block_cnt <= ld_block_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stb_dcache_drain.sv
// Store-buffer drain engine: pops the head entry of the store buffer and
// issues it as a word write to the dcache over a req/ack handshake.
// Optional feature macro: STB_DRAIN_PERF_EN (adds drain/stall/load-block
// performance counters and their output ports).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no write outstanding; pops the head entry when issue is allowed
// REQ   | write outstanding to the dcache, payload held until ack
module stb_dcache_drain
    import stb_dcache_drain_pkg::*;
#(
    parameter bit LD_PRIORITY = 1'b1
`ifdef STB_DRAIN_PERF_EN
    ,
    parameter int PERF_CNT_W  = 32
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stb_empty,
    input  logic [DCACHE_ADDR_WIDTH-1:0] stb_addr,
    input  logic [DCACHE_DATA_WIDTH-1:0] stb_wdata,
    input  logic [BLEN-1:0]              stb_sel_byte,
    output logic                         rd_sel,
    output logic                         rd_en,
    input  logic                         lsu2stb_ld_req,
    input  logic                         lsu2stb_fence_req,
    output logic                         stb2lsu_fence_done,
    output logic                         stb2dcache_req,
    output logic                         stb2dcache_w_en,
    output logic [DCACHE_ADDR_WIDTH-1:0] stb2dcache_addr,
    output logic [DCACHE_DATA_WIDTH-1:0] stb2dcache_wdata,
    output logic [BLEN-1:0]              stb2dcache_sel_byte,
    input  logic                         dcache2stb_ack
`ifdef STB_DRAIN_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]        drain_cnt,
    output logic [PERF_CNT_W-1:0]        stall_cnt,
    output logic [PERF_CNT_W-1:0]        ld_block_cnt
`endif
);

    stb_drain_state_t               state_q;
    stb_drain_state_t               state_d;
    logic                           ld_block;
    logic                           can_issue;
    logic                           pop;
    logic [DCACHE_ADDR_WIDTH-1:0]   addr_q;
    logic [DCACHE_DATA_WIDTH-1:0]   wdata_q;
    logic [BLEN-1:0]                sel_q;

    // A pending load only gates the start of a new store; an in-flight
    // request is never affected by it.
    assign ld_block  = LD_PRIORITY && lsu2stb_ld_req;
    assign can_issue = !stb_empty && !ld_block;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and pop decision; an ack in REQ may pop the next entry in
    // the same cycle so back-to-back stores issue one per cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    pop     = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dcache2stb_ack) begin
                    if (can_issue)
                        pop = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload registers load only on a pop, so they stay stable while the
    // request waits for its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else if (pop) begin
            addr_q  <= stb_addr;
            wdata_q <= stb_wdata;
            sel_q   <= stb_sel_byte;
        end
    end

    // The pop strobes are combinational from the buffer flags; gate them
    // with reset so nothing is popped while the block is held in reset.
    assign rd_sel = pop && rst_n;
    assign rd_en  = pop && rst_n;

    assign stb2dcache_req      = (state_q == REQ);
    assign stb2dcache_w_en     = stb2dcache_req;
    assign stb2dcache_addr     = addr_q;
    assign stb2dcache_wdata    = wdata_q;
    assign stb2dcache_sel_byte = sel_q;

    // Fence completes only once nothing is buffered and nothing is in flight.
    assign stb2lsu_fence_done  = lsu2stb_fence_req && stb_empty && (state_q == IDLE);

`ifdef STB_DRAIN_PERF_EN
    stb_dcache_drain_perf #(
        .PERF_CNT_W (PERF_CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .drain_inc    ((state_q == REQ) && dcache2stb_ack),
        .stall_inc    ((state_q == REQ) && !dcache2stb_ack),
        .ld_block_inc (!stb_empty && (state_q == IDLE) && ld_block),
        .drain_cnt    (drain_cnt),
        .stall_cnt    (stall_cnt),
        .ld_block_cnt (ld_block_cnt)
    );
`endif

endmodule

// File: tb/tb_stb_dcache_drain.sv
// Self-checking bench for stb_dcache_drain. The store buffer is modelled as
// a queue; expected outputs follow from the drain rules applied to that
// queue and to a single "write outstanding" flag.
`timescale 1ns/1ps
module tb_stb_dcache_drain;
    import stb_dcache_drain_pkg::*;

    localparam int AW = DCACHE_ADDR_WIDTH;
    localparam int DW = DCACHE_DATA_WIDTH;
    localparam int BW = BLEN;
    localparam int VW = 5 + AW + DW + BW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] s;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stb_empty;
    logic [AW-1:0] stb_addr;
    logic [DW-1:0] stb_wdata;
    logic [BW-1:0] stb_sel_byte;
    logic          rd_sel, rd_en;
    logic          lsu2stb_ld_req, lsu2stb_fence_req, stb2lsu_fence_done;
    logic          stb2dcache_req, stb2dcache_w_en;
    logic [AW-1:0] stb2dcache_addr;
    logic [DW-1:0] stb2dcache_wdata;
    logic [BW-1:0] stb2dcache_sel_byte;
    logic          dcache2stb_ack;
`ifdef STB_DRAIN_PERF_EN
    logic [31:0]   drain_cnt, stall_cnt, ld_block_cnt;
    int            m_drain, m_stall, m_ldb;
`endif

    always #5 clk = ~clk;

    stb_dcache_drain dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .stb_empty           (stb_empty),
        .stb_addr            (stb_addr),
        .stb_wdata           (stb_wdata),
        .stb_sel_byte        (stb_sel_byte),
        .rd_sel              (rd_sel),
        .rd_en               (rd_en),
        .lsu2stb_ld_req      (lsu2stb_ld_req),
        .lsu2stb_fence_req   (lsu2stb_fence_req),
        .stb2lsu_fence_done  (stb2lsu_fence_done),
        .stb2dcache_req      (stb2dcache_req),
        .stb2dcache_w_en     (stb2dcache_w_en),
        .stb2dcache_addr     (stb2dcache_addr),
        .stb2dcache_wdata    (stb2dcache_wdata),
        .stb2dcache_sel_byte (stb2dcache_sel_byte),
        .dcache2stb_ack      (dcache2stb_ack)
`ifdef STB_DRAIN_PERF_EN
        ,
        .drain_cnt           (drain_cnt),
        .stall_cnt           (stall_cnt),
        .ld_block_cnt        (ld_block_cnt)
`endif
    );

    int            checks = 0;
    int            fails  = 0;
    ent_t          sb[$];
    ent_t          pushed_log[$];
    ent_t          dut_done[$];
    logic          m_busy = 1'b0;
    ent_t          m_pay  = '0;
    logic [VW-1:0] obs_vec, exp_vec;
    int            n_pop, n_req;

    task automatic drive_head();
        stb_empty = (sb.size() == 0);
        if (sb.size() != 0) begin
            stb_addr     = sb[0].a;
            stb_wdata    = sb[0].d;
            stb_sel_byte = sb[0].s;
        end else begin
            stb_addr     = '0;
            stb_wdata    = '0;
            stb_sel_byte = '0;
        end
    endtask

    task automatic push(input ent_t e);
        sb.push_back(e);
        pushed_log.push_back(e);
        drive_head();
    endtask

    // One clock: sample DUT mid-cycle, form the expectation, advance model.
    task automatic step();
        logic can, exp_pop, exp_fd;
        ent_t got;
        #3;
        can     = (sb.size() != 0) && !lsu2stb_ld_req;
        exp_pop = can && (!m_busy || dcache2stb_ack);
        exp_fd  = lsu2stb_fence_req && (sb.size() == 0) && !m_busy;
        exp_vec = {m_busy, m_busy, exp_pop, exp_pop, exp_fd, m_pay};
        obs_vec = {stb2dcache_req, stb2dcache_w_en, rd_en, rd_sel, stb2lsu_fence_done,
                   stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte};
        if (rd_en) n_pop++;
        if (stb2dcache_req) n_req++;
        if (stb2dcache_req && dcache2stb_ack) begin
            got.a = stb2dcache_addr;
            got.d = stb2dcache_wdata;
            got.s = stb2dcache_sel_byte;
            dut_done.push_back(got);
        end
`ifdef STB_DRAIN_PERF_EN
        if (m_busy && dcache2stb_ack) m_drain++;
        if (m_busy && !dcache2stb_ack) m_stall++;
        if ((sb.size() != 0) && !m_busy && lsu2stb_ld_req) m_ldb++;
`endif
        @(posedge clk);
        if (exp_pop) begin
            m_pay  = sb.pop_front();
            m_busy = 1'b1;
        end else if (m_busy && dcache2stb_ack) begin
            m_busy = 1'b0;
        end
        #1;
        drive_head();
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        dcache2stb_ack    = 1'b0;
        lsu2stb_ld_req    = 1'b0;
        lsu2stb_fence_req = 1'b0;
        sb.delete();
        pushed_log.delete();
        dut_done.delete();
        m_busy = 1'b0;
        m_pay  = '0;
        n_pop  = 0;
        n_req  = 0;
`ifdef STB_DRAIN_PERF_EN
        m_drain = 0; m_stall = 0; m_ldb = 0;
`endif
        drive_head();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ent_t e;
        rst_n = 1'b0;
        dcache2stb_ack = 1'b0; lsu2stb_ld_req = 1'b0; lsu2stb_fence_req = 1'b0;
        e = '{a: 32'h0000_0040, d: 32'h1234_5678, s: 4'hF};
        push(e);
        #1;
        checks++;
        if ({stb2dcache_req, stb2dcache_w_en, rd_en, rd_sel, stb2lsu_fence_done,
             stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h required=0", {stb2dcache_req, rd_en, rd_sel,
                     stb2lsu_fence_done, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte});
        end
`ifdef STB_DRAIN_PERF_EN
        checks++;
        if ({drain_cnt, stall_cnt, ld_block_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_perf got=%0d/%0d/%0d required=0/0/0", drain_cnt, stall_cnt, ld_block_cnt);
        end
`endif
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL reset_idle c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_store();
        ent_t e;
        do_reset();
        e = '{a: 32'h0000_1000, d: 32'hDEAD_BEEF, s: 4'b1111};
        push(e);
        for (int i = 0; i < 6; i++) begin
            dcache2stb_ack = (i == 3);
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL single c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        dcache2stb_ack = 1'b0;
        checks++;
        if (n_pop != 1 || n_req != 3) begin
            fails++;
            $display("FAIL single_counts pops=%0d reqs=%0d required 1/3", n_pop, n_req);
        end
        checks++;
        if (dut_done.size() != 1 || dut_done[0] !== e) begin
            fails++;
            $display("FAIL single_payload writes=%0d required 1 of %h", dut_done.size(), e);
        end
    endtask

    task automatic test_back_to_back();
        ent_t e[3];
        do_reset();
        e[0] = '{a: 32'h100, d: 32'h11, s: 4'b0011};
        e[1] = '{a: 32'h104, d: 32'h22, s: 4'b0011};
        e[2] = '{a: 32'h108, d: 32'h33, s: 4'b0011};
        for (int i = 0; i < 3; i++) push(e[i]);
        dcache2stb_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL b2b c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        dcache2stb_ack = 1'b0;
        checks++;
        if (n_pop != 3 || n_req != 3) begin
            fails++;
            $display("FAIL b2b_counts pops=%0d reqs=%0d required 3/3", n_pop, n_req);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_done.size() <= i || dut_done[i] !== e[i]) begin
                fails++;
                $display("FAIL b2b_order idx%0d writes=%0d required %h", i, dut_done.size(), e[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        ent_t e;
        do_reset();
        e = '{a: 32'h0000_2000, d: 32'hCAFE_F00D, s: 4'b0101};
        push(e);
        lsu2stb_ld_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL ld_block c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        checks++;
        if (n_pop != 0 || n_req != 0) begin
            fails++;
            $display("FAIL ld_block_quiet pops=%0d reqs=%0d required 0/0", n_pop, n_req);
        end
        lsu2stb_ld_req = 1'b0;
        step();
        checks++;
        if (obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL ld_release got=%h required=%h", obs_vec, exp_vec);
        end
        // Load arrives while the store is in flight: must not disturb it.
        lsu2stb_ld_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dcache2stb_ack = (i == 2);
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL ld_inflight c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        dcache2stb_ack = 1'b0;
        lsu2stb_ld_req = 1'b0;
        checks++;
        if (dut_done.size() != 1 || dut_done[0] !== e) begin
            fails++;
            $display("FAIL ld_inflight_write writes=%0d required 1 of %h", dut_done.size(), e);
        end
    endtask

    task automatic test_fence();
        logic fd_seen[7];
        do_reset();
        lsu2stb_fence_req = 1'b1;
        push('{a: 32'h300, d: 32'hA5A5_0001, s: 4'hF});
        push('{a: 32'h304, d: 32'hA5A5_0002, s: 4'hC});
        for (int i = 0; i < 7; i++) begin
            dcache2stb_ack    = (i == 2) || (i == 4);
            lsu2stb_fence_req = (i != 6);
            step();
            fd_seen[i] = obs_vec[VW-5];
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL fence c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        dcache2stb_ack    = 1'b0;
        lsu2stb_fence_req = 1'b0;
        checks++;
        if ({fd_seen[0], fd_seen[1], fd_seen[2], fd_seen[3], fd_seen[4], fd_seen[5], fd_seen[6]}
                !== 7'b0000010) begin
            fails++;
            $display("FAIL fence_done_trace got=%b%b%b%b%b%b%b required=0000010", fd_seen[0],
                     fd_seen[1], fd_seen[2], fd_seen[3], fd_seen[4], fd_seen[5], fd_seen[6]);
        end
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        push('{a: 32'h0000_4000, d: 32'h0BAD_CAFE, s: 4'b1001});
        step();
        step();
        checks++;
        if (obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL midrst_pre got=%h required=%h", obs_vec, exp_vec);
        end
        // Keep a second entry queued so a pop would be possible during reset.
        push('{a: 32'h0000_4004, d: 32'h0000_0001, s: 4'b0001});
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stb2dcache_req, stb2dcache_w_en, rd_en, rd_sel,
             stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte} !== '0) begin
            fails++;
            $display("FAIL midrst_async got=%h required=0", {stb2dcache_req, stb2dcache_w_en, rd_en,
                     rd_sel, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte});
        end
        sb.delete();
        m_busy = 1'b0;
        m_pay  = '0;
        drive_head();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL midrst_post c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        ent_t e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() < 8 && ($urandom % 3) == 0) begin
                e.a = $urandom;
                e.d = $urandom;
                e.s = 4'($urandom);
                push(e);
            end
            dcache2stb_ack    = 1'($urandom % 2);
            lsu2stb_ld_req    = (($urandom % 4) == 0);
            lsu2stb_fence_req = (($urandom % 5) == 0);
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL random c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        lsu2stb_ld_req    = 1'b0;
        lsu2stb_fence_req = 1'b0;
        dcache2stb_ack    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL random_drain c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        dcache2stb_ack = 1'b0;
        checks++;
        if (dut_done.size() != pushed_log.size()) begin
            fails++;
            $display("FAIL random_count writes=%0d required=%0d", dut_done.size(), pushed_log.size());
        end
        for (int i = 0; i < pushed_log.size() && i < dut_done.size(); i++) begin
            checks++;
            if (dut_done[i] !== pushed_log[i]) begin
                fails++;
                $display("FAIL random_order idx%0d got=%h required=%h", i, dut_done[i], pushed_log[i]);
            end
        end
`ifdef STB_DRAIN_PERF_EN
        checks++;
        if (drain_cnt != m_drain || stall_cnt != m_stall || ld_block_cnt != m_ldb) begin
            fails++;
            $display("FAIL random_perf got=%0d/%0d/%0d required=%0d/%0d/%0d",
                     drain_cnt, stall_cnt, ld_block_cnt, m_drain, m_stall, m_ldb);
        end
`endif
    endtask

`ifdef STB_DRAIN_PERF_EN
    task automatic test_perf();
        do_reset();
        push('{a: 32'h500, d: 32'h1, s: 4'hF});
        push('{a: 32'h504, d: 32'h2, s: 4'hF});
        for (int i = 0; i < 11; i++) begin
            lsu2stb_ld_req = (i < 3);
            dcache2stb_ack = (i == 6) || (i == 9);
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL perf c%0d got=%h required=%h", i, obs_vec, exp_vec);
            end
        end
        lsu2stb_ld_req = 1'b0;
        dcache2stb_ack = 1'b0;
        checks++;
        if (drain_cnt != 2 || stall_cnt != 4 || ld_block_cnt != 3) begin
            fails++;
            $display("FAIL perf_counts got=%0d/%0d/%0d required=2/4/3", drain_cnt, stall_cnt, ld_block_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_store();
        test_back_to_back();
        test_load_priority();
        test_fence();
        test_reset_mid_request();
        test_random();
`ifdef STB_DRAIN_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/stb_dcache_drain.md
Name: stb_dcache_drain

Overview:
- Drain-side engine for the store buffer.
- Pops buffered stores from the store buffer datapath and issues each one as a word write to the dcache over a req/ack handshake.
- Holds request payload stable until ack; supports back-to-back pops on ack.
- Yields to pending LSU loads and answers LSU fence requests once the buffer is fully drained.

Parameters:
- LD_PRIORITY, 1, when 1 a pending load blocks issue of a new store (never aborts an in-flight one)
- PERF_CNT_W, 32, width of optional performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stb_empty  in  1  store buffer empty flag
- stb_addr  in  DCACHE_ADDR_WIDTH  head-entry address, valid while rd_sel=1
- stb_wdata  in  DCACHE_DATA_WIDTH  head-entry data
- stb_sel_byte  in  4  head-entry byte mask
- rd_sel  out  1  selects head entry onto stb_* inputs (combinational)
- rd_en  out  1  single-cycle pop pulse; advances read index next edge
- lsu2stb_ld_req  in  1  LSU load pending
- lsu2stb_fence_req  in  1  level fence request
- stb2lsu_fence_done  out  1  fence complete
- stb2dcache_req  out  1  write request valid
- stb2dcache_w_en  out  1  write qualifier, equals stb2dcache_req
- stb2dcache_addr  out  DCACHE_ADDR_WIDTH  registered address
- stb2dcache_wdata  out  DCACHE_DATA_WIDTH  registered data
- stb2dcache_sel_byte  out  4  registered byte mask
- dcache2stb_ack  in  1  write accepted/completed, single-cycle

Behaviour:
- Clock/reset: one clock clk; rst_n is asynchronous, active-low. On reset: state=IDLE, all outputs 0, payload registers 0, counters 0.
- States: IDLE, REQ.
- Issue condition: can_issue = !stb_empty && !(LD_PRIORITY && lsu2stb_ld_req).
- IDLE with can_issue:
  - rd_sel=1 and rd_en=1 combinationally.
  - Capture stb_addr, stb_wdata and stb_sel_byte into the payload registers at the edge.
  - Go to REQ.
- IDLE without can_issue: rd_sel=0, rd_en=0.
- REQ:
  - stb2dcache_req=1; payload held constant every cycle until ack.
  - lsu2stb_ld_req and lsu2stb_fence_req have no effect on the in-flight request.
- REQ with ack and can_issue: pop and capture the next entry in the same cycle (rd_sel=rd_en=1) and stay in REQ. req remains high into the next cycle with the new payload (back-to-back, 1 store per cycle if ack every cycle).
- REQ with ack and !can_issue: go to IDLE; req=0 next cycle.
- Ack while in IDLE: ignored, no state change.
- Latency: stb_empty falls at cycle N with no load pending -> stb2dcache_req=1 at N+1.
- rd_sel is 0 whenever no pop occurs in that cycle.
- Fence:
  - stb2lsu_fence_done = lsu2stb_fence_req && stb_empty && state==IDLE (combinational, level).
  - Deasserts as soon as lsu2stb_fence_req drops.
  - A fence does not block issue; draining continues normally.
- Full buffer: no special handling; this block only pops and is insensitive to full.
- Simultaneous LSU write and pop: the datapath handles both; this block requires nothing further.
- Reset mid-request: request dropped immediately (req=0 asynchronously). The popped entry is lost; the system resets the buffer too.

Optional Feature:
- Macro: STB_DRAIN_PERF_EN.
- With it:
  - drain_cnt (PERF_CNT_W) increments on every ack in REQ.
  - stall_cnt increments each cycle in REQ without ack.
  - ld_block_cnt increments each cycle where !stb_empty, state==IDLE and a load blocks issue.
  - All three are exposed as output ports; saturate at all-ones.
- Without it: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Package/cache_defs: DCACHE_ADDR_WIDTH, DCACHE_DATA_WIDTH, BLEN, state enum type stb_drain_state_t {IDLE, REQ}.
- Optional sub-module stb_drain_perf holds the three saturating counters, instantiated only under STB_DRAIN_PERF_EN. FSM and payload registers stay in the top.

Test Plan:
- Single store:
  - Stimulus: stb_empty 1->0 with addr=0x0000_1000, wdata=0xDEAD_BEEF, sel=4'b1111; ack 3 cycles after req.
  - Required: one rd_en pulse; req high 3 cycles with payload stable; req low after ack; fence_done stays 0 unless fence_req is high.
- Back-to-back:
  - Stimulus: 3 entries (0x100/0x11, 0x104/0x22, 0x108/0x33, sel 4'b0011), ack every cycle.
  - Required: 3 consecutive req cycles with payloads in order, exactly 3 rd_en pulses, then IDLE.
- Load priority:
  - Stimulus: entry present, lsu2stb_ld_req=1 for 4 cycles.
  - Required: no rd_en/req during those cycles; req asserted 1 cycle after ld_req drops.
  - Stimulus: ld_req raised during REQ.
  - Required: payload held, ack completes the store.
- Fence:
  - Stimulus: fence_req=1 with 2 entries queued, ack after 2 cycles each.
  - Required: fence_done=0 until the second ack and return to IDLE with stb_empty=1, then 1; drops the cycle fence_req falls.
- Reset mid-request:
  - Stimulus: rst_n low while req=1.
  - Required: req, rd_en, rd_sel and payload outputs go 0 immediately; after release, IDLE and no spurious req while stb_empty=1.
- Perf (macro defined):
  - Stimulus: 2 stores with 2 stall cycles each, plus 3 load-blocked cycles.
  - Required: drain_cnt=2, stall_cnt=4, ld_block_cnt=3.
